// File: rtl/sw_debounce.sv
// Switch synchroniser and per-bit debouncer feeding the PIO in_port.
// Define SW_DEBOUNCE_EDGE_EN to build the registered sw_rise/sw_fall pulse outputs.
module sw_debounce #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A bit is pending while its synchronised level disagrees with the clean level;
    // the counter only survives an unbroken run of disagreement.
    always_comb begin
        clean_d = clean_q;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = '0;
            if (sync_s[b] != clean_q[b]) begin
                if (cnt_q[b] == CNT_MAX) begin
                    clean_d[b] = sync_s[b];
                    cnt_d[b]   = '0;
                end else begin
                    cnt_d[b]   = cnt_q[b] + CNT_W'(1);
                end
            end else begin
                cnt_d[b] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_q <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            clean_q <= clean_d;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign sw_clean = clean_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // Pulses are registered alongside clean_q so they line up with its transition.
    always_comb begin
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: directed scenarios plus random switch activity,
// checked against a "last D synchronised samples all disagree" reference model.
module tb_sw_debounce;

    localparam int W = 3;
    localparam int S = 2;
    localparam int D = 8;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .sw_clean(sw_clean),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           n_vec = 0;
    int           n_err = 0;

    // Reference model state: raw samples still travelling through the synchroniser,
    // the last D synchronised samples, and the accepted level.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_win[$];
    logic [W-1:0] m_clean = '0;

    task automatic model_edge(input logic [W-1:0] raw, input logic rst);
        logic [W-1:0] rd;
        logic [W-1:0] oldest;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         all_diff;
        rise = '0;
        fall = '0;
        if (rst) begin
            m_pipe.delete();
            m_win.delete();
            for (int i = 0; i < S; i++) m_pipe.push_back('0);
            for (int i = 0; i < D; i++) m_win.push_back('0);
            m_clean = '0;
        end else begin
            rd = m_pipe.pop_front();
            m_pipe.push_back(raw);
            oldest = m_win.pop_front();
            m_win.push_back(rd);
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                foreach (m_win[j]) begin
                    if (m_win[j][b] == m_clean[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_clean[b] = rd[b];
                    rise[b]    = rd[b];
                    fall[b]    = ~rd[b];
                end
            end
        end
`ifndef SW_DEBOUNCE_EDGE_EN
        rise = '0;
        fall = '0;
`endif
        exp_q.push_back('{clean: m_clean, rise: rise, fall: fall});
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic step(input logic [W-1:0] raw, input logic rst);
        @(negedge clk);
        sw_raw = raw;
        reset  = rst;
        model_edge(raw, rst);
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ({sw_clean, sw_rise, sw_fall} !== mon_e) begin
                n_err++;
                $display("FAIL outputs t=%0t clean/rise/fall got %b/%b/%b want %b/%b/%b",
                         $time, sw_clean, sw_rise, sw_fall, mon_e.clean, mon_e.rise, mon_e.fall);
            end
        end
    end

    initial begin
        int           hold_cnt [W];
        logic [W-1:0] rnd_raw;

        // Reset with all switches closed, then full-latency acceptance of 3'b111.
        for (int i = 0; i < 3; i++) step(3'b111, 1'b1);
        hold(3'b111, 14);
        hold(3'b000, 14);

        // Single bit rise and fall.
        hold(3'b001, 14);
        hold(3'b000, 14);

        // Short pulses on bit 1: 7 cycles rejected, 9 cycles accepted.
        hold(3'b010, 7);
        hold(3'b000, 14);
        hold(3'b010, 9);
        hold(3'b000, 14);

        // Bouncing bit 2 settling high.
        for (int i = 0; i < 30; i++) step((((i / 3) % 2) == 1) ? 3'b100 : 3'b000, 1'b0);
        hold(3'b100, 14);
        hold(3'b000, 14);

        // Reset landing in the middle of a pending change.
        hold(3'b001, 5);
        step(3'b001, 1'b1);
        step(3'b001, 1'b1);
        hold(3'b001, 14);
        hold(3'b000, 14);

        // Independent random activity per bit with occasional resets.
        rnd_raw = '0;
        for (int b = 0; b < W; b++) hold_cnt[b] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < W; b++) begin
                if (hold_cnt[b] == 0) begin
                    rnd_raw[b]  = 1'($urandom_range(0, 1));
                    hold_cnt[b] = int'($urandom_range(1, 14));
                end else begin
                    hold_cnt[b] = hold_cnt[b] - 1;
                end
            end
            step(rnd_raw, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        hold(3'b000, 14);

        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
